// File: rtl/dmem_dump_if.sv
// Bus between the post-execution dump transmitter, data memory read port,
// the UART transmitter and the top-level status/trigger signals.
interface dmem_dump_if;
    logic        CPU_finish_execution;
    logic        transmitter_buffer_full;
    logic [7:0]  dump_read_data;
    logic [31:0] dump_read_address;
    logic        DMEM_transmit_request;
    logic [7:0]  DMEM_data_transmit;
    logic [31:0] DMEM_transmit_address;
    logic        dump_busy;
    logic        dump_done;

    modport master (
        input  CPU_finish_execution,
        input  transmitter_buffer_full,
        input  dump_read_data,
        output dump_read_address,
        output DMEM_transmit_request,
        output DMEM_data_transmit,
        output DMEM_transmit_address,
        output dump_busy,
        output dump_done
    );

    modport slave (
        output CPU_finish_execution,
        output transmitter_buffer_full,
        output dump_read_data,
        input  dump_read_address,
        input  DMEM_transmit_request,
        input  DMEM_data_transmit,
        input  DMEM_transmit_address,
        input  dump_busy,
        input  dump_done
    );
endinterface

// File: rtl/dmem_dump_transmitter.sv
// Walks a fixed DMEM window after the core halts and streams each byte to the
// UART transmitter, one byte per WAIT/SEND/GAP round, honouring buffer-full.
module dmem_dump_transmitter #(
    parameter logic [31:0] DUMP_START_ADDRESS = 32'h0000_0000,
    parameter int unsigned DUMP_LENGTH        = 256
) (
    input  logic         clk,
    input  logic         SYS_reset,
    dmem_dump_if.master  bus
);
    localparam logic [15:0] LEN16 = 16'(DUMP_LENGTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_SEND = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [15:0] count_q, count_d;
    logic        req_q, req_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] taddr_q, taddr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next-state and registered-output logic for the dump sequencer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        req_d   = 1'b0;
        data_d  = data_q;
        taddr_d = taddr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.CPU_finish_execution) begin
                    if (LEN16 == 16'd0) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.transmitter_buffer_full) begin
                    state_d = ST_SEND;
                    data_d  = bus.dump_read_data;
                    taddr_d = ptr_q;
                    req_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SEND: begin
                ptr_d   = ptr_q + 32'd1;
                count_d = count_q + 16'd1;
                state_d = ST_GAP;
            end
            // Count already includes the byte just sent, so compare directly
            ST_GAP: begin
                if (count_q == LEN16) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (SYS_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= DUMP_START_ADDRESS;
            count_q <= 16'd0;
            req_q   <= 1'b0;
            data_q  <= 8'd0;
            taddr_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            req_q   <= req_d;
            data_q  <= data_d;
            taddr_q <= taddr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dump_read_address     = ptr_q;
    assign bus.DMEM_transmit_request = req_q;
    assign bus.DMEM_data_transmit    = data_q;
    assign bus.DMEM_transmit_address = taddr_q;
    assign bus.dump_busy             = busy_q;
    assign bus.dump_done             = done_q;
endmodule
